eth_tx_sf_fifo: RTL and testbench

Store-and-forward packet FIFO on the 10G TX path, directly upstream of the MAC's 32-bit Avalon-ST TX sink, in the `tx_clk_156` domain. It buffers each complete packet before releasing it, so the MAC never sees a mid-packet underrun. Packets that overflow the buffer, arrive malformed, or (optionally) carry an error flag are dropped whole and counted. Status outputs feed the HSSI CSR statistics.

---
 rtl/eth_tx_sf_fifo_if.sv | 28 ++
 rtl/eth_tx_sf_fifo.sv | 183 ++++++++++++++++++
 tb/tb_eth_tx_sf_fifo.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_sf_fifo_if.sv
// rtl/eth_tx_sf_fifo_if.sv - sink and source beat signals of the TX store-and-forward FIFO
`timescale 1ns/1ps
interface eth_tx_sf_fifo_if;
   logic        in_valid;
   logic        in_sop;
   logic        in_eop;
   logic [31:0] in_data;
   logic [1:0]  in_empty;
   logic        in_error;
   logic        in_ready;
   logic        out_valid;
   logic        out_sop;
   logic        out_eop;
   logic [31:0] out_data;
   logic [1:0]  out_empty;
   logic        out_error;
   logic        out_ready;

   modport slave (
      input  in_valid, in_sop, in_eop, in_data, in_empty, in_error, out_ready,
      output in_ready, out_valid, out_sop, out_eop, out_data, out_empty, out_error
   );

   modport master (
      output in_valid, in_sop, in_eop, in_data, in_empty, in_error, out_ready,
      input  in_ready, out_valid, out_sop, out_eop, out_data, out_empty, out_error
   );
endinterface

// File: rtl/eth_tx_sf_fifo.sv
// rtl/eth_tx_sf_fifo.sv - store-and-forward packet FIFO ahead of the 10G MAC TX sink
`timescale 1ns/1ps
module eth_tx_sf_fifo #(
   parameter int ADDR_W   = 9,
   parameter bit DROP_ERR = 1'b0
) (
   input  logic              tx_clk_156,
   input  logic              tx_rst_n,
   eth_tx_sf_fifo_if.slave   bus,
   output logic [31:0]       drop_cnt,
   output logic [ADDR_W:0]   pkt_cnt,
   output logic [ADDR_W:0]   fill_lvl
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int PW    = ADDR_W + 1;

   typedef enum logic [1:0] {W_IDLE, W_WR, W_DISCARD} wr_state_e;
   typedef enum logic {R_IDLE, R_SEND} rd_state_e;

   // Word layout: {error, empty[1:0], eop, sop, data[31:0]}
   logic [36:0]       mem [DEPTH];

   wr_state_e         wr_state_q, wr_state_d;
   rd_state_e         rd_state_q, rd_state_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     commit_ptr_q, commit_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     fetch_ptr_q, fetch_ptr_d;
   logic [PW-1:0]     pkt_cnt_q, pkt_cnt_d;
   logic [31:0]       drop_cnt_q, drop_cnt_d;
   logic              orphan_q, orphan_d;
   logic              in_ready_q;
   logic              rvld_q;
   logic [36:0]       rdata_q;
   logic [36:0]       sk0_q, sk1_q;
   logic [1:0]        sk_cnt_q;

   logic              beat;
   logic [36:0]       in_word;
   logic [PW-1:0]     base;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_en;
   logic              commit;
   logic [1:0]        drop_inc;
   logic [32:0]       drop_sum;
   logic              pop;
   logic              eop_done;
   logic              rd_en;

   assign beat    = bus.in_valid && in_ready_q;
   assign in_word = {bus.in_error, bus.in_empty, bus.in_eop, bus.in_sop, bus.in_data};

   always_comb begin
      wr_state_d   = wr_state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      orphan_d     = orphan_q;
      base         = wr_ptr_q;
      wr_en        = 1'b0;
      commit       = 1'b0;
      drop_inc     = 2'd0;
      if (beat) begin
         if (wr_state_q == W_DISCARD) begin
            if (bus.in_eop) wr_state_d = W_IDLE;
         end else if (wr_state_q == W_IDLE && !bus.in_sop) begin
            if (!orphan_q) drop_inc = 2'd1;
            orphan_d = 1'b1;
         end else begin
            // A sop always restarts from the last commit point, abandoning any partial packet
            if (bus.in_sop) begin
               orphan_d = 1'b0;
               base     = commit_ptr_q;
               if (wr_state_q == W_WR) drop_inc = 2'd1;
            end
            if ((base - rd_ptr_q) == PW'(DEPTH)) begin
               wr_ptr_d   = commit_ptr_q;
               drop_inc   = drop_inc + 2'd1;
               wr_state_d = bus.in_eop ? W_IDLE : W_DISCARD;
            end else begin
               wr_en = 1'b1;
               if (bus.in_eop) begin
                  wr_state_d = W_IDLE;
                  if (DROP_ERR && bus.in_error) begin
                     wr_ptr_d = commit_ptr_q;
                     drop_inc = drop_inc + 2'd1;
                  end else begin
                     wr_ptr_d     = base + PW'(1);
                     commit_ptr_d = base + PW'(1);
                     commit       = 1'b1;
                  end
               end else begin
                  wr_ptr_d   = base + PW'(1);
                  wr_state_d = W_WR;
               end
            end
         end
      end
   end

   assign wr_addr    = base[ADDR_W-1:0];
   assign drop_sum   = {1'b0, drop_cnt_q} + 33'(drop_inc);
   assign drop_cnt_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];

   assign pop         = (sk_cnt_q != 2'd0) && bus.out_ready;
   assign eop_done    = pop && sk0_q[33];
   assign pkt_cnt_d   = pkt_cnt_q + PW'(commit) - PW'(eop_done);
   assign rd_ptr_d    = rd_ptr_q + PW'(pop);
   // Only issue a read if the word is guaranteed a skid slot when it lands next cycle
   assign rd_en       = (rd_state_q == R_SEND) && (fetch_ptr_q != commit_ptr_q) &&
                        (({1'b0, sk_cnt_q} + {2'b0, rvld_q}) <= ({2'b0, pop} + 3'd1));
   assign fetch_ptr_d = fetch_ptr_q + PW'(rd_en);

   always_comb begin
      rd_state_d = rd_state_q;
      unique case (rd_state_q)
         R_IDLE: if (pkt_cnt_q != '0) rd_state_d = R_SEND;
         R_SEND: if (eop_done && pkt_cnt_d == '0) rd_state_d = R_IDLE;
         default: rd_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge tx_clk_156) begin
      if (wr_en) mem[wr_addr] <= in_word;
      if (rd_en) rdata_q <= mem[fetch_ptr_q[ADDR_W-1:0]];
   end

   always_ff @(posedge tx_clk_156 or negedge tx_rst_n) begin
      if (!tx_rst_n) begin
         wr_state_q   <= W_IDLE;
         rd_state_q   <= R_IDLE;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         fetch_ptr_q  <= '0;
         pkt_cnt_q    <= '0;
         drop_cnt_q   <= '0;
         orphan_q     <= 1'b0;
         in_ready_q   <= 1'b0;
         rvld_q       <= 1'b0;
         sk0_q        <= '0;
         sk1_q        <= '0;
         sk_cnt_q     <= 2'd0;
      end else begin
         wr_state_q   <= wr_state_d;
         rd_state_q   <= rd_state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fetch_ptr_q  <= fetch_ptr_d;
         pkt_cnt_q    <= pkt_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         orphan_q     <= orphan_d;
         in_ready_q   <= 1'b1;
         rvld_q       <= rd_en;
         if (rvld_q && !pop) begin
            if (sk_cnt_q == 2'd0) sk0_q <= rdata_q;
            else                  sk1_q <= rdata_q;
            sk_cnt_q <= sk_cnt_q + 2'd1;
         end else if (!rvld_q && pop) begin
            sk0_q    <= sk1_q;
            sk_cnt_q <= sk_cnt_q - 2'd1;
         end else if (rvld_q && pop) begin
            if (sk_cnt_q == 2'd1) begin
               sk0_q <= rdata_q;
            end else begin
               sk0_q <= sk1_q;
               sk1_q <= rdata_q;
            end
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = (sk_cnt_q != 2'd0);
   assign bus.out_data  = sk0_q[31:0];
   assign bus.out_sop   = sk0_q[32];
   assign bus.out_eop   = sk0_q[33];
   assign bus.out_empty = sk0_q[35:34];
   assign bus.out_error = sk0_q[36];
   assign drop_cnt      = drop_cnt_q;
   assign pkt_cnt       = pkt_cnt_q;
   assign fill_lvl      = wr_ptr_q - rd_ptr_q;
endmodule

// File: tb/tb_eth_tx_sf_fifo.sv
// tb/tb_eth_tx_sf_fifo.sv - randomized self-checking bench for eth_tx_sf_fifo
`timescale 1ns/1ps
module tb_eth_tx_sf_fifo;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   eth_tx_sf_fifo_if bus_a();
   eth_tx_sf_fifo_if bus_b();

   logic [31:0] drop_a, drop_b;
   logic [9:0]  pkt_a, fill_a;
   logic [6:0]  pkt_b, fill_b;

   eth_tx_sf_fifo u_dut_a (
      .tx_clk_156 (clk),
      .tx_rst_n   (rst_n),
      .bus        (bus_a),
      .drop_cnt   (drop_a),
      .pkt_cnt    (pkt_a),
      .fill_lvl   (fill_a)
   );

   eth_tx_sf_fifo #(.ADDR_W(6), .DROP_ERR(1'b1)) u_dut_b (
      .tx_clk_156 (clk),
      .tx_rst_n   (rst_n),
      .bus        (bus_b),
      .drop_cnt   (drop_b),
      .pkt_cnt    (pkt_b),
      .fill_lvl   (fill_b)
   );

   initial forever #5 clk = ~clk;

   logic        drv_valid = 0, drv_sop = 0, drv_eop = 0, drv_err = 0, drv_sel = 0;
   logic [31:0] drv_data = 0;
   logic [1:0]  drv_empty = 0;
   logic        rdy_fix_a = 0, rdy_fix_b = 0, rdy_rand_a = 0, rnd_bit = 0;

   assign bus_a.in_valid  = drv_valid && !drv_sel;
   assign bus_b.in_valid  = drv_valid && drv_sel;
   assign bus_a.in_sop    = drv_sop;
   assign bus_b.in_sop    = drv_sop;
   assign bus_a.in_eop    = drv_eop;
   assign bus_b.in_eop    = drv_eop;
   assign bus_a.in_data   = drv_data;
   assign bus_b.in_data   = drv_data;
   assign bus_a.in_empty  = drv_empty;
   assign bus_b.in_empty  = drv_empty;
   assign bus_a.in_error  = drv_err;
   assign bus_b.in_error  = drv_err;
   assign bus_a.out_ready = rdy_rand_a ? rnd_bit : rdy_fix_a;
   assign bus_b.out_ready = rdy_fix_b;

   initial forever begin
      @(posedge clk);
      #1 rnd_bit = 1'($urandom_range(0, 1));
   end

   int n_checks = 0;
   int n_pass = 0;
   logic [36:0] exp_a[$], exp_b[$], got_a[$], got_b[$];
   int drop_exp_a = 0, drop_exp_b = 0, fill_model_b = 0;
   int a_gaps = 0, a_unstable = 0;
   bit a_inpkt = 0, a_hold = 0;
   logic [36:0] a_prev, cur_a, cur_b;

   // Output monitor: collects accepted beats and watches for gaps and held-beat changes
   always @(negedge clk) begin
      cur_a = {bus_a.out_error, bus_a.out_empty, bus_a.out_eop, bus_a.out_sop, bus_a.out_data};
      cur_b = {bus_b.out_error, bus_b.out_empty, bus_b.out_eop, bus_b.out_sop, bus_b.out_data};
      if (!rst_n) begin
         a_inpkt = 0;
         a_hold  = 0;
      end else begin
         if (a_hold && (!bus_a.out_valid || cur_a !== a_prev)) a_unstable++;
         if (a_inpkt && !bus_a.out_valid) a_gaps++;
         if (bus_a.out_valid && bus_a.out_ready) begin
            got_a.push_back(cur_a);
            a_inpkt = !bus_a.out_eop;
         end
         if (bus_b.out_valid && bus_b.out_ready) got_b.push_back(cur_b);
         a_hold = bus_a.out_valid && !bus_a.out_ready;
         a_prev = cur_a;
      end
   end

   task automatic send_beat(input bit s, input bit l, input bit e, input logic [31:0] d, input logic [1:0] em);
      drv_valid = 1; drv_sop = s; drv_eop = l; drv_err = e; drv_data = d; drv_empty = em;
      @(posedge clk);
      #1 drv_valid = 0;
   endtask

   task automatic send_pkt(input int len, input bit err, input bit keep, input bit to_b, input int emp);
      logic [31:0] d;
      logic [1:0]  e;
      bit          s, l;
      drv_sel = to_b;
      for (int i = 0; i < len; i++) begin
         d = $urandom;
         s = (i == 0);
         l = (i == len - 1);
         e = !l ? 2'd0 : (emp < 0) ? 2'($urandom_range(0, 3)) : 2'(emp);
         if (keep && to_b)  exp_b.push_back({l & err, e, l, s, d});
         if (keep && !to_b) exp_a.push_back({l & err, e, l, s, d});
         send_beat(s, l, l & err, d, e);
      end
   endtask

   task automatic wait_got(input bit b, input int n, input int limit);
      for (int i = 0; i < limit; i++) begin
         if ((b ? got_b.size() : got_a.size()) >= n) break;
         @(negedge clk);
      end
   endtask

   task automatic clear_q();
      exp_a.delete(); exp_b.delete(); got_a.delete(); got_b.delete();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++; if (bus_a.in_ready !== 1'b0) $display("FAIL reset_in_ready got %0b want 0", bus_a.in_ready); else n_pass++;
      n_checks++; if ({bus_a.out_valid, bus_a.out_sop, bus_a.out_eop, bus_a.out_error} !== 4'b0)
         $display("FAIL reset_out_flags got %b want 0000", {bus_a.out_valid, bus_a.out_sop, bus_a.out_eop, bus_a.out_error}); else n_pass++;
      n_checks++; if ({bus_a.out_data, bus_a.out_empty} !== 34'd0) $display("FAIL reset_out_data got %h want 0", bus_a.out_data); else n_pass++;
      n_checks++; if ({drop_a, pkt_a, fill_a} !== 52'd0) $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", drop_a, pkt_a, fill_a); else n_pass++;
      @(posedge clk); #1 rst_n = 1;
      @(posedge clk); #1;
      n_checks++; if (bus_a.in_ready !== 1'b1) $display("FAIL ready_after_reset got %0b want 1", bus_a.in_ready); else n_pass++;
   endtask

   task automatic test_single();
      clear_q();
      rdy_fix_a = 1;
      send_pkt(16, 0, 1, 0, 2);
      @(negedge clk);
      n_checks++; if (pkt_a !== 10'd1) $display("FAIL single_pkt_cnt got %0d want 1", pkt_a); else n_pass++;
      @(negedge clk); @(negedge clk);
      n_checks++; if (bus_a.out_valid !== 1'b0) $display("FAIL single_early_valid got %0b want 0 after E2", bus_a.out_valid); else n_pass++;
      @(negedge clk);
      n_checks++; if (bus_a.out_valid !== 1'b1) $display("FAIL single_latency got %0b want 1 after E3", bus_a.out_valid); else n_pass++;
      wait_got(0, 16, 100);
      n_checks++; if (got_a.size() != exp_a.size()) $display("FAIL single_count got %0d want %0d", got_a.size(), exp_a.size()); else n_pass++;
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         n_checks++; if (got_a[i] !== exp_a[i]) $display("FAIL single_beat%0d got %h want %h", i, got_a[i], exp_a[i]); else n_pass++;
      end
      if (got_a.size() == 16) begin
         n_checks++; if (got_a[15][35:34] !== 2'd2) $display("FAIL single_empty got %0d want 2", got_a[15][35:34]); else n_pass++;
      end
      n_checks++; if (drop_a !== 32'd0) $display("FAIL single_drop got %0d want 0", drop_a); else n_pass++;
   endtask

   task automatic test_back_to_back();
      clear_q();
      rdy_rand_a = 1;
      for (int p = 0; p < 50; p++) begin
         for (int w = 0; w < 2000 && int'(fill_a) > 512 - 64; w++) @(posedge clk);
         #1 send_pkt($urandom_range(1, 64), 0, 1, 0, -1);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      wait_got(0, exp_a.size(), 20000);
      rdy_rand_a = 0;
      repeat (3) @(negedge clk);
      n_checks++; if (got_a.size() != exp_a.size()) $display("FAIL b2b_count got %0d want %0d", got_a.size(), exp_a.size()); else n_pass++;
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         n_checks++; if (got_a[i] !== exp_a[i]) $display("FAIL b2b_beat%0d got %h want %h", i, got_a[i], exp_a[i]); else n_pass++;
      end
      n_checks++; if (pkt_a !== 10'd0 || fill_a !== 10'd0) $display("FAIL b2b_drain got pkt %0d fill %0d want 0 0", pkt_a, fill_a); else n_pass++;
      n_checks++; if (a_gaps !== 0) $display("FAIL b2b_gaps got %0d want 0", a_gaps); else n_pass++;
      n_checks++; if (a_unstable !== 0) $display("FAIL b2b_hold_stable got %0d want 0", a_unstable); else n_pass++;
      n_checks++; if (drop_a !== 32'(drop_exp_a)) $display("FAIL b2b_drop got %0d want %0d", drop_a, drop_exp_a); else n_pass++;
   endtask

   task automatic test_overflow();
      clear_q();
      rdy_fix_b = 0;
      for (int p = 0; p < 2; p++) begin
         if (fill_model_b + 40 > 64) begin
            drop_exp_b++;
            send_pkt(40, 0, 0, 1, -1);
         end else begin
            fill_model_b += 40;
            send_pkt(40, 0, 1, 1, -1);
         end
      end
      repeat (5) @(negedge clk);
      n_checks++; if (drop_b !== 32'(drop_exp_b)) $display("FAIL ovf_drop got %0d want %0d", drop_b, drop_exp_b); else n_pass++;
      n_checks++; if (fill_b !== 7'(fill_model_b)) $display("FAIL ovf_fill got %0d want %0d", fill_b, fill_model_b); else n_pass++;
      n_checks++; if (pkt_b !== 7'd1) $display("FAIL ovf_pkt_cnt got %0d want 1", pkt_b); else n_pass++;
      rdy_fix_b = 1;
      wait_got(1, exp_b.size(), 300);
      repeat (20) @(negedge clk);
      n_checks++; if (got_b.size() != exp_b.size()) $display("FAIL ovf_count got %0d want %0d", got_b.size(), exp_b.size()); else n_pass++;
      for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
         n_checks++; if (got_b[i] !== exp_b[i]) $display("FAIL ovf_beat%0d got %h want %h", i, got_b[i], exp_b[i]); else n_pass++;
      end
      n_checks++; if (fill_b !== 7'd0) $display("FAIL ovf_fill_end got %0d want 0", fill_b); else n_pass++;
      fill_model_b = 0;
   endtask

   task automatic test_malformed();
      clear_q();
      rdy_fix_a = 1;
      drv_sel = 0;
      send_beat(0, 0, 0, $urandom, 0);
      send_beat(0, 0, 0, $urandom, 0);
      drop_exp_a++;
      send_beat(1, 0, 0, $urandom, 0);
      for (int i = 0; i < 3; i++) send_beat(0, 0, 0, $urandom, 0);
      drop_exp_a++;
      send_pkt(5, 0, 1, 0, -1);
      wait_got(0, exp_a.size(), 100);
      repeat (10) @(negedge clk);
      n_checks++; if (drop_a !== 32'(drop_exp_a)) $display("FAIL malformed_drop got %0d want %0d", drop_a, drop_exp_a); else n_pass++;
      n_checks++; if (got_a.size() != exp_a.size()) $display("FAIL malformed_count got %0d want %0d", got_a.size(), exp_a.size()); else n_pass++;
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         n_checks++; if (got_a[i] !== exp_a[i]) $display("FAIL malformed_beat%0d got %h want %h", i, got_a[i], exp_a[i]); else n_pass++;
      end
   endtask

   task automatic test_error();
      clear_q();
      rdy_fix_b = 1;
      rdy_fix_a = 1;
      drop_exp_b++;
      send_pkt(5, 1, 0, 1, -1);
      repeat (15) @(negedge clk);
      n_checks++; if (got_b.size() != 0) $display("FAIL err_drop_out got %0d beats want 0", got_b.size()); else n_pass++;
      n_checks++; if (drop_b !== 32'(drop_exp_b)) $display("FAIL err_drop_cnt got %0d want %0d", drop_b, drop_exp_b); else n_pass++;
      n_checks++; if (pkt_b !== 7'd0 || fill_b !== 7'd0) $display("FAIL err_drop_lvl got pkt %0d fill %0d want 0 0", pkt_b, fill_b); else n_pass++;
      send_pkt(6, 1, 1, 0, -1);
      wait_got(0, exp_a.size(), 100);
      n_checks++; if (got_a.size() != exp_a.size()) $display("FAIL err_pass_count got %0d want %0d", got_a.size(), exp_a.size()); else n_pass++;
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         n_checks++; if (got_a[i] !== exp_a[i]) $display("FAIL err_pass_beat%0d got %h want %h", i, got_a[i], exp_a[i]); else n_pass++;
      end
      if (got_a.size() == 6) begin
         n_checks++; if (got_a[5][36] !== 1'b1) $display("FAIL err_flag_eop got %0b want 1", got_a[5][36]); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      clear_q();
      rdy_fix_a = 0;
      send_pkt(10, 0, 1, 0, -1);
      for (int i = 0; i < 50 && !bus_a.out_valid; i++) @(negedge clk);
      @(posedge clk); #1 rdy_fix_a = 1;
      repeat (3) @(posedge clk);
      #1 rdy_fix_a = 0;
      send_beat(1, 0, 0, $urandom, 0);
      for (int i = 0; i < 3; i++) send_beat(0, 0, 0, $urandom, 0);
      @(negedge clk);
      n_checks++; if (got_a.size() != 3) $display("FAIL rst_pre_count got %0d want 3", got_a.size()); else n_pass++;
      for (int i = 0; i < 3 && i < got_a.size(); i++) begin
         n_checks++; if (got_a[i] !== exp_a[i]) $display("FAIL rst_pre_beat%0d got %h want %h", i, got_a[i], exp_a[i]); else n_pass++;
      end
      #2 rst_n = 0;
      #1;
      n_checks++; if ({bus_a.out_valid, bus_a.out_sop, bus_a.out_eop, bus_a.out_error, bus_a.out_data, bus_a.out_empty} !== 38'd0)
         $display("FAIL rst_mid_outputs got %b_%h want 0", {bus_a.out_valid, bus_a.out_sop, bus_a.out_eop, bus_a.out_error}, bus_a.out_data); else n_pass++;
      n_checks++; if ({drop_a, pkt_a, fill_a} !== 52'd0) $display("FAIL rst_mid_counters got %0d/%0d/%0d want 0/0/0", drop_a, pkt_a, fill_a); else n_pass++;
      n_checks++; if (bus_a.in_ready !== 1'b0) $display("FAIL rst_mid_ready got %0b want 0", bus_a.in_ready); else n_pass++;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      drop_exp_a = 0;
      clear_q();
      rdy_fix_a = 1;
      repeat (2) @(posedge clk);
      #1 send_pkt(12, 0, 1, 0, -1);
      wait_got(0, exp_a.size(), 100);
      repeat (3) @(negedge clk);
      n_checks++; if (got_a.size() != exp_a.size()) $display("FAIL rst_post_count got %0d want %0d", got_a.size(), exp_a.size()); else n_pass++;
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         n_checks++; if (got_a[i] !== exp_a[i]) $display("FAIL rst_post_beat%0d got %h want %h", i, got_a[i], exp_a[i]); else n_pass++;
      end
      n_checks++; if (fill_a !== 10'd0 || drop_a !== 32'(drop_exp_a)) $display("FAIL rst_post_lvl got fill %0d drop %0d want 0 %0d", fill_a, drop_a, drop_exp_a); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_malformed();
      test_error();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
